tile_spawner: RTL and testbench
===============================

Name: tile_spawner

Overview:
- Sits directly downstream of the 4x4 node grid and closes the loop back into it.
- After a move completes, it reads all 16 cell values and picks one empty cell with a free-running LFSR.
- It writes a new tile (exponent 1 = "2", optionally 2 = "4") into that cell through the nodes' preset path.
- If the board has no empty cell, it reports full instead.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be non-zero.
- MAX_TRIES, 8, random probes before falling back to a deterministic pick; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to spawn a tile; ignored while busy
- board  in  64  cell values; cell i occupies bits [4i+3:4i]; value 0 means empty
- preset_ext  out  16  one-hot per-cell preset strobe, one cycle wide, to the nodes' preset_ext
- value_preset  out  4  value placed on the nodes' value_from_preset; valid while preset_ext is non-zero
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- full  out  1  valid with done; 1 = no empty cell, nothing written

Behaviour:
- Reset values: all outputs 0, state IDLE, LFSR = LFSR_SEED, try counter 0. Reset mid-operation aborts the operation with no preset and no done.
- LFSR: 16-bit Galois, right shift, feedback mask 16'hB400. It advances every cycle rst is low, in every state.
- States: IDLE, SCAN, PICK, FALLBACK, WRITE, DONE. Outputs are decoded from registered state; there are no combinational paths from input to output.
- IDLE: when start=1, latch board into a snapshot register and go to SCAN. Board changes after this edge are ignored.
- SCAN: build empty_mask[i] = (snapshot cell i == 0).
  - empty_mask == 0: set full register to 1 and go to DONE.
  - Otherwise clear full, clear the try counter and go to PICK.
- PICK: index = lfsr[3:0].
  - empty_mask[index] = 1: latch index and go to WRITE.
  - Otherwise increment the try counter.
  - If the counter reaches MAX_TRIES, go to FALLBACK.
- FALLBACK: latch the lowest-index set bit of empty_mask and go to WRITE.
- WRITE: drive preset_ext = 1 << index and value_preset = 1 for exactly one cycle, then go to DONE.
- DONE: done=1 for one cycle, full holds its result, then go to IDLE. full returns to 0 in IDLE.
- busy = (state != IDLE).
- A start during busy is dropped, not queued.
- A start in the same cycle as rst is ignored.
- Latency from the start edge: best case, preset in cycle 3 and done in cycle 4. Worst case, preset in cycle MAX_TRIES+3 and done in cycle MAX_TRIES+4. Full-board case: done in cycle 2.
- Exactly one cell is written per accepted start. An occupied cell is never written.

Optional Feature:
- Macro SPAWN_FOUR_EN.
- Defined: in WRITE, value_preset = 2 when the LFSR bits [11:8] sampled at the PICK/FALLBACK decision equal 0 (1/16 probability); otherwise 1. The sample is latched alongside index.
- Undefined: value_preset is always 1.

Decomposition:
- Shared package game_pkg holds:
  - CELL_W = 4 and N_CELLS = 16
  - LFSR_POLY = 16'hB400
  - the spawner state enum
  - the VALUE_TWO = 1 and VALUE_FOUR = 2 constants
- One sub-module, lfsr16 (clk, rst, seed parameter, 16-bit state out), reusable by other random consumers.

Test Plan:
- Empty board, start at cycle 0 → busy in cycles 1..4. preset_ext = 1 << (LFSR[3:0] at PICK), value_preset = 1 in cycle 3, done in cycle 4, full=0. Bench uses a reference LFSR model from seed 16'hACE1.
- All 16 cells = 4'h3, start → no preset_ext activity, done=1 with full=1 in cycle 2, busy low by cycle 3.
- MAX_TRIES=1, only cell 9 empty, probed index ≠ 9 → FALLBACK is taken; preset_ext = 16'h0200 in cycle 4, done in cycle 5.
- Board changed to all-full one cycle after start → the snapshot is used and a tile is still written into an originally empty cell; start pulses during busy produce no second done.
- rst asserted in PICK → all outputs 0 next cycle, no done; a fresh start afterwards reproduces the seed-based sequence from scenario 1.
- SPAWN_FOUR_EN defined, 2000 spawns on an empty board → value_preset ∈ {1,2}, and the count of 2s is within 90..160. Undefined → all values equal 1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants and types for the 2048 board datapath.
package game_pkg;

  localparam int          CELL_W     = 4;
  localparam int          N_CELLS    = 16;
  localparam logic [15:0] LFSR_POLY  = 16'hB400;
  localparam logic [3:0]  VALUE_TWO  = 4'd1;
  localparam logic [3:0]  VALUE_FOUR = 4'd2;

  typedef enum logic [2:0] {
    SP_IDLE,
    SP_SCAN,
    SP_PICK,
    SP_FALLBACK,
    SP_WRITE,
    SP_DONE
  } spawn_state_e;

  // Descending scan so the last hit is the lowest set bit.
  function automatic logic [3:0] lowest_set(input logic [N_CELLS-1:0] mask);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = N_CELLS - 1; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (right shift), reloaded with SEED on reset.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_POLY : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/tile_spawner.sv
// Picks a random empty cell after a move and presets a new tile into it.
// Build option: define SPAWN_FOUR_EN to occasionally spawn a "4" instead of a "2".
module tile_spawner
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_CELLS*CELL_W-1:0] board,
  output logic [N_CELLS-1:0]        preset_ext,
  output logic [CELL_W-1:0]         value_preset,
  output logic                      busy,
  output logic                      done,
  output logic                      full
);

  localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);

  spawn_state_e              state_q, state_d;
  logic [N_CELLS*CELL_W-1:0] snap_q, snap_d;
  logic [3:0]                tries_q, tries_d;
  logic [3:0]                index_q, index_d;
  logic                      full_q, full_d;
  logic [N_CELLS-1:0]        empty_mask;
  logic [15:0]               lfsr_state;
  logic                      lfsr_unused;
  logic [3:0]                probe;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_state)
  );

  assign probe       = lfsr_state[3:0];
  assign lfsr_unused = ^lfsr_state;

  always_comb begin
    empty_mask = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      empty_mask[i] = (snap_q[i*CELL_W +: CELL_W] == '0);
    end
  end

`ifdef SPAWN_FOUR_EN
  logic four_q, four_d;
  logic four_roll;
  assign four_roll = (lfsr_state[11:8] == 4'd0);
`endif

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    tries_d = tries_q;
    index_d = index_q;
    full_d  = full_q;
`ifdef SPAWN_FOUR_EN
    four_d  = four_q;
`endif
    case (state_q)
      SP_IDLE: begin
        full_d = 1'b0;
        if (start) begin
          snap_d  = board;
          state_d = SP_SCAN;
        end
      end
      SP_SCAN: begin
        if (empty_mask == '0) begin
          full_d  = 1'b1;
          state_d = SP_DONE;
        end else begin
          full_d  = 1'b0;
          tries_d = 4'd0;
          state_d = SP_PICK;
        end
      end
      SP_PICK: begin
        if (empty_mask[probe]) begin
          index_d = probe;
`ifdef SPAWN_FOUR_EN
          four_d  = four_roll;
`endif
          state_d = SP_WRITE;
        end else begin
          tries_d = tries_q + 4'd1;
          if (tries_q + 4'd1 == TRY_LIMIT) state_d = SP_FALLBACK;
        end
      end
      SP_FALLBACK: begin
        index_d = lowest_set(empty_mask);
`ifdef SPAWN_FOUR_EN
        four_d  = four_roll;
`endif
        state_d = SP_WRITE;
      end
      SP_WRITE: state_d = SP_DONE;
      // full stays visible alongside done, then clears on the way back to idle
      SP_DONE: begin
        full_d  = 1'b0;
        state_d = SP_IDLE;
      end
      default: state_d = SP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SP_IDLE;
      snap_q  <= '0;
      tries_q <= '0;
      index_q <= '0;
      full_q  <= 1'b0;
`ifdef SPAWN_FOUR_EN
      four_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      tries_q <= tries_d;
      index_q <= index_d;
      full_q  <= full_d;
`ifdef SPAWN_FOUR_EN
      four_q  <= four_d;
`endif
    end
  end

  always_comb begin
    preset_ext   = '0;
    value_preset = '0;
    if (state_q == SP_WRITE) begin
      preset_ext = {{(N_CELLS-1){1'b0}}, 1'b1} << index_q;
`ifdef SPAWN_FOUR_EN
      value_preset = four_q ? VALUE_FOUR : VALUE_TWO;
`else
      value_preset = VALUE_TWO;
`endif
    end
  end

  assign busy = (state_q != SP_IDLE);
  assign done = (state_q == SP_DONE);
  assign full = full_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Bench for tile_spawner: two instances (MAX_TRIES 8 and 1) share stimulus and are
// compared every cycle against a transaction-level prediction of each spawn.
module tb_tile_spawner;
  import game_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int MT0 = 8;
  localparam int MT1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] board = '0;

  logic [15:0] preset_o [2];
  logic [3:0]  value_o  [2];
  logic        busy_o   [2];
  logic        done_o   [2];
  logic        full_o   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_spawner #(.LFSR_SEED(SEED), .MAX_TRIES(MT0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .board(board),
    .preset_ext(preset_o[0]), .value_preset(value_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .full(full_o[0])
  );

  tile_spawner #(.LFSR_SEED(SEED), .MAX_TRIES(MT1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .board(board),
    .preset_ext(preset_o[1]), .value_preset(value_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .full(full_o[1])
  );

  // Expected outcome of one accepted start, in cycles relative to the start edge.
  typedef struct packed {
    int          write_rel;
    int          done_rel;
    logic [15:0] preset;
    logic [3:0]  value;
    logic        full;
  } pred_t;

  function automatic logic [15:0] step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // l0 is the random value during the cycle in which start is sampled;
  // cycle c after that edge sees step applied c times.
  function automatic pred_t predict(input logic [63:0] b, input logic [15:0] l0, input int mt);
    pred_t       p;
    logic [15:0] l;
    int          n_empty, first_empty, idx;
    bit          hit;
    n_empty = 0; first_empty = 0; idx = 0; hit = 1'b0;
    for (int j = 15; j >= 0; j--) begin
      if (b[j*4 +: 4] == 4'd0) begin n_empty++; first_empty = j; end
    end
    p = '0;
    if (n_empty == 0) begin
      p.full = 1'b1; p.write_rel = -1; p.done_rel = 2;
      return p;
    end
    l = step(step(l0));
    for (int k = 0; k < mt && !hit; k++) begin
      idx = int'(l[3:0]);
      if (b[idx*4 +: 4] == 4'd0) begin hit = 1'b1; p.write_rel = 3 + k; end
      else l = step(l);
    end
    if (!hit) begin idx = first_empty; p.write_rel = mt + 3; end
`ifdef SPAWN_FOUR_EN
    p.value = (l[11:8] == 4'd0) ? 4'd2 : 4'd1;
`else
    p.value = 4'd1;
`endif
    p.preset   = 16'h0001 << idx;
    p.done_rel = p.write_rel + 1;
    return p;
  endfunction

  pred_t       mp       [2];
  bit          m_active [2] = '{1'b0, 1'b0};
  int          m_rel    [2] = '{0, 0};
  logic [15:0] m_lfsr;

  // Model advances at each active edge, reading the same inputs the DUT samples.
  always @(posedge clk) begin
    if (rst) begin
      m_lfsr <= SEED;
      for (int i = 0; i < 2; i++) begin m_active[i] <= 1'b0; m_rel[i] <= 0; end
    end else begin
      m_lfsr <= step(m_lfsr);
      for (int i = 0; i < 2; i++) begin
        if (m_active[i]) begin
          if (m_rel[i] == mp[i].done_rel) m_active[i] <= 1'b0;
          m_rel[i] <= m_rel[i] + 1;
        end else if (start) begin
          mp[i]       <= predict(board, m_lfsr, (i == 0) ? MT0 : MT1);
          m_active[i] <= 1'b1;
          m_rel[i]    <= 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int inst, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst=%0d t=%0t got=%h expected=%h", name, inst, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        eb, ed, ef;
      logic [15:0] ep;
      eb = m_active[i];
      ed = m_active[i] && (m_rel[i] == mp[i].done_rel);
      ef = ed && mp[i].full;
      ep = (m_active[i] && m_rel[i] == mp[i].write_rel) ? mp[i].preset : 16'h0000;
      checkOutput("busy", i, 32'(busy_o[i]), 32'(eb));
      checkOutput("done", i, 32'(done_o[i]), 32'(ed));
      checkOutput("full", i, 32'(full_o[i]), 32'(ef));
      checkOutput("preset_ext", i, 32'(preset_o[i]), 32'(ep));
      if (ep != 16'h0000) checkOutput("value_preset", i, 32'(value_o[i]), 32'(mp[i].value));
    end
  end

  // Per-transaction observations gathered by applyStimulus.
  int          r_done_cyc   [2];
  int          r_done_cnt   [2];
  int          r_preset_cyc [2];
  logic [15:0] r_preset     [2];
  logic [3:0]  r_value      [2];
  logic        r_full       [2];
  logic        r_busy       [2][64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1; start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [63:0] b, input bit change_board,
                               input logic [63:0] b_late, input bit extra_start);
    int  post;
    bit  finished;
    post = 0; finished = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r_done_cyc[i] = -1; r_done_cnt[i] = 0; r_preset_cyc[i] = -1;
      r_preset[i] = '0; r_value[i] = '0; r_full[i] = 1'b0;
      for (int c = 0; c < 64; c++) r_busy[i][c] = 1'b0;
    end
    board = b;
    start = 1'b1;
    for (int c = 1; c <= 40 && !finished; c++) begin
      tick();
      start = extra_start && (c == 2 || c == 3);
      if (c == 1 && change_board) board = b_late;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        r_busy[i][c] = busy_o[i];
        if (done_o[i]) begin
          r_done_cnt[i]++;
          if (r_done_cyc[i] < 0) begin r_done_cyc[i] = c; r_full[i] = full_o[i]; end
        end
        if (preset_o[i] != 16'h0000) begin
          r_preset_cyc[i] = c; r_preset[i] = preset_o[i]; r_value[i] = value_o[i];
        end
      end
      if (r_done_cyc[0] >= 0 && r_done_cyc[1] >= 0) begin
        post++;
        if (post >= 3) finished = 1'b1;
      end
    end
    start = 1'b0;
    if (!finished) begin
      checks++; errors++;
      $display("[TB] FAIL done_timeout got done_cyc=%0d/%0d expected done within 40 cycles",
               r_done_cyc[0], r_done_cyc[1]);
    end
  endtask

  initial begin
    logic [63:0] b;
    logic [15:0] l2;
    int          twos;

    // Reset and model pinning
    resetDut();
    checkOutput("model_seed", 0, 32'(m_lfsr), 32'h0000ACE1);
    l2 = step(16'hACE1);
    checkOutput("model_step1", 0, 32'(l2), 32'h0000E270);
    l2 = step(l2);
    checkOutput("model_step2", 0, 32'(l2), 32'h00007138);

    // Empty board straight after reset: probe is 0x7138 -> cell 8
    applyStimulus(64'h0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("s1_busy_c1", i, 32'(r_busy[i][1]), 32'd1);
      checkOutput("s1_busy_c4", i, 32'(r_busy[i][4]), 32'd1);
      checkOutput("s1_busy_c5", i, 32'(r_busy[i][5]), 32'd0);
      checkOutput("s1_preset", i, 32'(r_preset[i]), 32'h00000100);
      checkOutput("s1_preset_cyc", i, 32'(r_preset_cyc[i]), 32'd3);
      checkOutput("s1_value", i, 32'(r_value[i]), 32'd1);
      checkOutput("s1_done_cyc", i, 32'(r_done_cyc[i]), 32'd4);
      checkOutput("s1_full", i, 32'(r_full[i]), 32'd0);
    end

    // Full board: no preset, done with full in cycle 2
    applyStimulus({16{4'h3}}, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("s2_done_cyc", i, 32'(r_done_cyc[i]), 32'd2);
      checkOutput("s2_full", i, 32'(r_full[i]), 32'd1);
      checkOutput("s2_no_preset", i, 32'(r_preset_cyc[i]), 32'hFFFFFFFF);
      checkOutput("s2_busy_c3", i, 32'(r_busy[i][3]), 32'd0);
    end

    // Only cell 9 empty, first probe chosen to miss: MAX_TRIES=1 instance falls back
    for (int w = 0; w < 20; w++) begin
      l2 = step(step(m_lfsr));
      if (l2[3:0] != 4'd9) break;
      tick();
    end
    b = {16{4'h3}};
    b[39:36] = 4'h0;
    applyStimulus(b, 1'b0, 64'h0, 1'b0);
    checkOutput("s3_fallback_preset", 1, 32'(r_preset[1]), 32'h00000200);
    checkOutput("s3_fallback_preset_cyc", 1, 32'(r_preset_cyc[1]), 32'd4);
    checkOutput("s3_fallback_done_cyc", 1, 32'(r_done_cyc[1]), 32'd5);
    checkOutput("s3_preset_mt8", 0, 32'(r_preset[0]), 32'h00000200);

    // Snapshot: board goes full after start; extra starts while busy are dropped
    b = {16{4'h3}};
    b[11:8]  = 4'h0;
    b[55:52] = 4'h0;
    applyStimulus(b, 1'b1, {16{4'h3}}, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checkOutput("s4_preset_snapshot", i, 32'(r_preset[i]),
                  (r_preset[i] == 16'h2000) ? 32'h00002000 : 32'h00000004);
      checkOutput("s4_full", i, 32'(r_full[i]), 32'd0);
      checkOutput("s4_done_count", i, 32'(r_done_cnt[i]), 32'd1);
    end

    // Reset while in PICK, then start during reset, then a fresh start
    board = 64'h0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("s5_rst_busy", i, 32'(busy_o[i]), 32'd0);
      checkOutput("s5_rst_done", i, 32'(done_o[i]), 32'd0);
      checkOutput("s5_rst_preset", i, 32'(preset_o[i]), 32'd0);
    end
    tick();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) checkOutput("s5_start_with_rst", i, 32'(busy_o[i]), 32'd0);
    checkOutput("s5_model_seed", 0, 32'(m_lfsr), 32'h0000ACE1);
    applyStimulus(64'h0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("s5_repeat_preset", i, 32'(r_preset[i]), 32'h00000100);
      checkOutput("s5_repeat_done_cyc", i, 32'(r_done_cyc[i]), 32'd4);
    end

    // Many spawns on an empty board; tally spawned fours
    twos = 0;
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(64'h0, 1'b0, 64'h0, 1'b0);
      if (r_value[0] == 4'd2) twos++;
    end
`ifdef SPAWN_FOUR_EN
    checks++;
    if (twos < 90 || twos > 160) begin
      errors++;
      $display("[TB] FAIL four_count got=%0d expected 90..160", twos);
    end
`else
    checkOutput("four_count", 0, 32'(twos), 32'd0);
`endif

    // Random sparse/dense/full boards, checked by the per-cycle model
    for (int n = 0; n < 300; n++) begin
      int mode, sel;
      mode = $urandom_range(0, 2);
      sel  = $urandom_range(0, 15);
      for (int j = 0; j < 16; j++) begin
        b[j*4 +: 4] = 4'($urandom_range(1, 15));
        if ((mode == 0 && j == sel) || (mode == 1 && $urandom_range(0, 3) == 0) ||
            (mode == 2 && $urandom_range(0, 15) == 0))
          b[j*4 +: 4] = 4'h0;
      end
      applyStimulus(b, 1'b0, 64'h0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
